// File: rtl/y_relu_pool.sv
// ReLU + max-pool + round/shift/saturate stage for the signed y stream.
// Results leave through a 2-entry FIFO carrying {data, end-of-frame}.
module y_relu_pool #(
   parameter int IN_W  = 18,
   parameter int OUT_W = 8,
   parameter int POOL  = 2,
   parameter int FRAME = 5,
   parameter int SHIFT = 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [IN_W-1:0]  s_data_in_y,
   input  logic                    s_valid_y,
   output logic                    s_ready_y,
   output logic signed [OUT_W-1:0] m_data_out_z,
   output logic                    m_valid_z,
   input  logic                    m_ready_z,
   output logic                    m_last_z
);

   localparam int WCW = (POOL > 1) ? $clog2(POOL) : 1;
   localparam int FCW = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam logic [IN_W:0] RND  = (IN_W+1)'(1) << (SHIFT - 1);
   localparam logic [IN_W:0] QMAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);

   logic [WCW-1:0]   win_cnt_q, win_cnt_d;
   logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
   logic [IN_W-1:0]  mx_q, mx_d;
   logic [1:0]       count_q, count_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [OUT_W-1:0] buf_data_q [2];
   logic [OUT_W-1:0] buf_data_d [2];
   logic [1:0]       buf_last_q, buf_last_d;

   logic             accept, win_last, frame_last, close, push, pop;
   logic [IN_W-1:0]  r, m;
   logic [IN_W:0]    sum, q;
   logic [OUT_W-1:0] q_sat;

   assign s_ready_y    = reset && (count_q != 2'd2);
   assign m_valid_z    = (count_q != 2'd0);
   assign m_data_out_z = m_valid_z ? buf_data_q[rd_ptr_q] : '0;
   assign m_last_z     = m_valid_z && buf_last_q[rd_ptr_q];

   always_comb begin
      accept     = s_valid_y && s_ready_y;
      r          = s_data_in_y[IN_W-1] ? '0 : s_data_in_y;
      // The first sample of a window replaces the running max outright.
      if (win_cnt_q == '0) m = r;
      else                 m = (r > mx_q) ? r : mx_q;
      win_last   = (win_cnt_q == WCW'(POOL - 1));
      frame_last = (frame_cnt_q == FCW'(FRAME - 1));
      close      = accept && (win_last || frame_last);
      sum        = {1'b0, m} + RND;
      q          = sum >> SHIFT;
      q_sat      = (q > QMAX) ? OUT_W'(QMAX) : OUT_W'(q);
      push       = close;
      pop        = m_valid_z && m_ready_z;

      mx_d        = mx_q;
      win_cnt_d   = win_cnt_q;
      frame_cnt_d = frame_cnt_q;
      if (accept) begin
         mx_d        = m;
         win_cnt_d   = close ? '0 : win_cnt_q + WCW'(1);
         frame_cnt_d = frame_last ? '0 : frame_cnt_q + FCW'(1);
      end

      buf_data_d = buf_data_q;
      buf_last_d = buf_last_q;
      if (push) begin
         buf_data_d[wr_ptr_q] = q_sat;
         buf_last_d[wr_ptr_q] = frame_last;
      end
      count_d  = count_q + 2'(push) - 2'(pop);
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_cnt_q     <= '0;
         frame_cnt_q   <= '0;
         mx_q          <= '0;
         count_q       <= '0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         buf_data_q[0] <= '0;
         buf_data_q[1] <= '0;
         buf_last_q    <= '0;
      end else begin
         win_cnt_q   <= win_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         mx_q        <= mx_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         buf_data_q  <= buf_data_d;
         buf_last_q  <= buf_last_d;
      end
   end

endmodule

// File: tb/tb_y_relu_pool.sv
// Scoreboard bench for y_relu_pool: directed frames, backpressure, random stalls, mid-frame reset.
// Expected {data,last} is queued at stimulus time and popped by an independent output monitor.
module tb_y_relu_pool;

   logic               clk = 1'b0;
   logic               reset;
   logic signed [17:0] s_data_in_y;
   logic               s_valid_y;
   logic               s_ready_y;
   logic signed [7:0]  m_data_out_z;
   logic               m_valid_z;
   logic               m_ready_z;
   logic               m_last_z;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random
   bit   rand_idle = 0;

   int f1 [5] = '{-2800, 3600, 400, 1600, 2800};
   int e1 [3] = '{113, 50, 88};
   int f2 [5] = '{400, 6000, -2000, 2200, 600};
   int e2 [3] = '{127, 69, 19};
   int f3 [5] = '{10, 14, 18, 22, 26};
   int e3 [3] = '{0, 1, 1};
   int f4 [5] = '{-5, -1, -100, -7, -3};
   int e4 [3] = '{0, 0, 0};

   y_relu_pool dut (
      .clk          (clk),
      .reset        (reset),
      .s_data_in_y  (s_data_in_y),
      .s_valid_y    (s_valid_y),
      .s_ready_y    (s_ready_y),
      .m_data_out_z (m_data_out_z),
      .m_valid_z    (m_valid_z),
      .m_ready_z    (m_ready_z),
      .m_last_z     (m_last_z)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Sole driver of m_ready_z; applied at posedge+2 so main-process mode changes at posedge+1 take effect in the same cycle.
   initial begin
      m_ready_z = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (rdy_mode)
            0:       m_ready_z = 1'b0;
            1:       m_ready_z = 1'b1;
            default: m_ready_z = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor: a transfer is committed at the coming posedge when valid && ready at negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (m_valid_z && m_ready_z) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got data=%0d last=%0d with empty scoreboard", m_data_out_z, m_last_z);
            end else begin
               e = exp_q.pop_front();
               $display("OUT data=%0d last=%0d (expected %0d/%0d)", m_data_out_z, m_last_z, e.data, e.last);
               chk("out_data", int'(m_data_out_z), int'(e.data));
               chk("out_last", int'(m_last_z), int'(e.last));
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input int x);
      int n;
      if (rand_idle) begin
         s_valid_y = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      s_data_in_y = 18'(x);
      s_valid_y   = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_ready_y && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      s_valid_y   = 1'b0;
      s_data_in_y = '0;
   endtask

   task automatic push_exp(input int e [3]);
      for (int i = 0; i < 3; i++) exp_q.push_back({8'(e[i]), (i == 2)});
   endtask

   // With lat_chk, m_ready_z must be 1 and there are no idle cycles: a result is visible
   // exactly after its closing edge and already consumed by the next accept edge.
   task automatic send_frame(input int v [5], input int e [3], input bit lat_chk);
      push_exp(e);
      for (int i = 0; i < 5; i++) begin
         send(v[i]);
         if (lat_chk) chk($sformatf("latency_valid_s%0d", i), int'(m_valid_z), int'(i == 1 || i == 3 || i == 4));
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      reset       = 1'b0;
      s_valid_y   = 1'b0;
      s_data_in_y = '0;
      #2;
      chk("rst_m_valid", int'(m_valid_z), 0);
      chk("rst_m_last", int'(m_last_z), 0);
      chk("rst_m_data", int'(m_data_out_z), 0);
      chk("rst_s_ready", int'(s_ready_y), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_s_ready", int'(s_ready_y), 1);
      chk("post_rst_m_valid", int'(m_valid_z), 0);

      // Directed frames, consumer always ready, latency checked.
      rdy_mode = 1;
      @(posedge clk);
      #1;
      send_frame(f1, e1, 1'b1);
      send_frame(f2, e2, 1'b1);
      send_frame(f3, e3, 1'b1);
      send_frame(f4, e4, 1'b1);
      drain();

      // Backpressure: four samples fill the buffer, the fifth is held off.
      rdy_mode = 0;
      @(posedge clk);
      #1;
      push_exp(e1);
      for (int i = 0; i < 4; i++) send(f1[i]);
      chk("bp_s_ready_low", int'(s_ready_y), 0);
      s_data_in_y = 18'(f1[4]);
      s_valid_y   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold_s_ready", int'(s_ready_y), 0);
         chk("bp_hold_valid", int'(m_valid_z), 1);
         chk("bp_hold_head", int'(m_data_out_z), 113);
      end
      @(posedge clk);
      #1;
      rdy_mode = 1;
      send(f1[4]);
      drain();

      // Random input gaps and consumer stalls over four back-to-back frames.
      rdy_mode  = 2;
      rand_idle = 1'b1;
      send_frame(f1, e1, 1'b0);
      send_frame(f2, e2, 1'b0);
      send_frame(f3, e3, 1'b0);
      send_frame(f4, e4, 1'b0);
      rand_idle = 1'b0;
      rdy_mode  = 1;
      drain();

      // Mid-frame reset with a result sitting in the buffer.
      rdy_mode = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send(f1[i]);
      chk("pre_rst_valid", int'(m_valid_z), 1);
      chk("pre_rst_head", int'(m_data_out_z), 113);
      reset = 1'b0;
      #1;
      chk("midrst_m_valid", int'(m_valid_z), 0);
      chk("midrst_m_data", int'(m_data_out_z), 0);
      chk("midrst_m_last", int'(m_last_z), 0);
      chk("midrst_s_ready", int'(s_ready_y), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("after_rst_m_valid", int'(m_valid_z), 0);
      rdy_mode = 1;
      @(posedge clk);
      #1;
      send_frame(f1, e1, 1'b1);
      drain();
      repeat (5) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/y_relu_pool.md
Name: y_relu_pool

Overview:
- Downstream stage of the 8x4 convolution engine.
- Consumes the signed 18-bit y stream over a valid/ready handshake and applies ReLU.
- Max-pools over windows of POOL consecutive samples inside fixed-length frames of FRAME samples, then rounds and right-shifts each pooled value and saturates it to OUT_W bits.
- Emits results through a 2-entry output buffer with its own valid/ready handshake and an end-of-frame flag.

Parameters:
IN_W, 18, input sample width (signed)
OUT_W, 8, output sample width (signed; ReLU output is always non-negative)
POOL, 2, samples per pooling window (>=1)
FRAME, 5, samples per frame (one conv output set); the last window of a frame may be partial
SHIFT, 5, arithmetic right shift applied after pooling, with round-half-up (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
s_data_in_y  in  IN_W  signed input sample
s_valid_y  in  1  input sample valid
s_ready_y  out  1  block can accept an input sample
m_data_out_z  out  OUT_W  signed pooled/quantized result
m_valid_z  out  1  result valid
m_ready_z  in  1  consumer accepts result
m_last_z  out  1  result is the last of its frame; qualified by m_valid_z

Behaviour:
- Reset (reset==0, asynchronous): win_cnt=0, frame_cnt=0, running max=0, buffer count=0.
  - Outputs during and after reset: m_valid_z=0, m_last_z=0, m_data_out_z=0.
  - s_ready_y is forced 0 while reset is asserted.
  - Asserting reset mid-frame discards the partial window and all buffered results. After release, the next accepted sample is sample 0 of a new frame.
- Input acceptance: a sample is accepted on a rising edge where s_valid_y && s_ready_y.
  - s_ready_y = (count != 2). It is registered state only, with no combinational path from m_ready_z.
  - Samples arriving while s_valid_y==0 are ignored; data may be X.
- ReLU: r = (x < 0) ? 0 : x.
- Pooling: if win_cnt==0, mx <= r; otherwise mx <= max(mx, r).
- Window closes on an accepted sample when win_cnt==POOL-1 or frame_cnt==FRAME-1.
  - On close, win_cnt <= 0. Otherwise win_cnt increments.
  - frame_cnt increments on every accepted sample and wraps to 0 after FRAME-1. frame_cnt wrap also forces win_cnt to 0 (partial final window).
- Quantize, computed on the closing value m = max(mx, r), or m = r when win_cnt==0:
  - q = (m + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits with no overflow.
  - Saturate: if q > 2^(OUT_W-1)-1, output 2^(OUT_W-1)-1; otherwise output q.
- Buffer: 2-entry FIFO holding {data, last}. last = (frame_cnt==FRAME-1) at close.
  - The push happens on the closing acceptance edge, so the result is visible on m_valid_z the next cycle (latency 1).
  - m_valid_z = (count != 0). m_data_out_z/m_last_z come from the head entry and hold stable while m_valid_z && !m_ready_z.
  - Pop occurs when m_valid_z && m_ready_z.
- Simultaneous push and pop: count is unchanged and ordering is preserved. This applies at count==1; at count==2 no push is possible.
- Non-closing samples still require s_ready_y; the block never accepts while count==2.
- Throughput: one input per cycle sustained when m_ready_z is held 1.

Test Plan:
- POOL=2, FRAME=5, SHIFT=5, OUT_W=8; m_ready_z=1.
  - Feed -2800, 3600, 400, 1600, 2800 -> outputs 113, 50, 88.
  - m_last_z is 0, 0, 1.
  - Each result appears 1 cycle after its closing sample.
- Saturation: feed 400, 6000, -2000, 2200, 600 -> outputs 127 (6000 saturates), 69, 19; last on the third.
- Rounding, small values: feed 10, 14, 18, 22, 26 -> outputs 0 (14+16=30>>5), 1 (38>>5), 1 (42>>5).
  - Then feed all-negative frame -5, -1, -100, -7, -3 -> outputs 0, 0, 0.
- Backpressure:
  - m_ready_z=0 and first frame fed continuously -> s_ready_y drops the cycle after the second result is pushed (after 4 accepted samples).
  - The 5th sample is held off, and head data 113 stays stable.
  - Raising m_ready_z -> 113, 50, 88 drain in order with no loss or duplication.
- Random s_valid_y/m_ready_z toggling over 4 back-to-back frames -> output sequence identical to the unstalled run; m_last_z every 3rd output.
- Reset mid-frame: accept -2800, 3600, 400, then assert reset -> m_valid_z=0 immediately and the buffer is empty.
  - After release, feed the first frame -> 113, 50, 88 with correct m_last_z; there is no residue from the aborted frame.
